// File: rtl/piso_serializer_if.sv
// ---------------------------------------------------------------------------
// piso_serializer_if
//   Bundles the parallel load handshake and the serial line of the
//   piso_serializer into one port.
//
//   Signals:
//     data_in    [WIDTH-1:0]  parallel word offered by the producer
//     load_valid              producer offers data_in
//     load_ready              serializer can accept a word (idle)
//     sdata                   serial data line, registered
//     sframe                  high while a frame's bits are on sdata
//     done                    one-cycle pulse after the last bit period
//
//   Modports:
//     master  producer / line observer side (drives data_in, load_valid)
//     slave   serializer side (drives load_ready and the serial outputs)
// ---------------------------------------------------------------------------
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             sdata;
    logic             sframe;
    logic             done;

    modport master (
        output data_in,
        output load_valid,
        input  load_ready,
        input  sdata,
        input  sframe,
        input  done
    );

    modport slave (
        input  data_in,
        input  load_valid,
        output load_ready,
        output sdata,
        output sframe,
        output done
    );
endinterface

// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
//   Parallel-in / serial-out transmitter. A WIDTH-bit word is taken through a
//   valid/ready handshake and shifted out on sdata, one bit per BIT_CYCLES
//   clock cycles, MSB or LSB first. sframe marks the bits of a frame and done
//   pulses for one cycle after the last bit period. The far end is a plain
//   D-flop chain acting as a SIPO receiver.
//
//   Optional feature (compile-time macro PISO_PARITY_EN):
//     When defined, an even-parity bit (XOR of the captured word) follows the
//     data bits for one more bit period, still inside sframe.
//     When undefined, no parity state or parity logic exists.
//
//   Parameters:
//     WIDTH       data word width, >= 2 (must match the interface WIDTH)
//     MSB_FIRST   1: bit WIDTH-1 first (shift left); 0: bit 0 first
//     BIT_CYCLES  clock cycles each serial bit is held, >= 1
//
//   Ports:
//     clk   system clock, rising edge
//     rst   synchronous reset, active low
//     bus   piso_serializer_if.slave: data_in, load_valid, load_ready,
//           sdata, sframe, done
//
//   sdata, sframe and done come straight from flops; load_ready is decoded
//   from the state register only.
// ---------------------------------------------------------------------------
module piso_serializer #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int BIT_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    piso_serializer_if.slave    bus
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int BW = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
`ifdef PISO_PARITY_EN
    localparam logic [1:0] ST_PARITY = 2'd2;
`endif

    logic [1:0]       state;
    logic [WIDTH-1:0] sreg;
    logic [BW-1:0]    bcnt;
    logic [CW-1:0]    ccnt;
    logic             sframe_q;
    logic             done_q;
`ifdef PISO_PARITY_EN
    logic             par_q;
    logic [WIDTH-1:0] par_vec;
`endif

    logic             bit_end;
    logic             last_bit;
    logic [WIDTH-1:0] shifted;

    // Terminal count of the per-bit cycle counter; constant 1 when
    // BIT_CYCLES=1 because the counter never leaves 0.
    assign bit_end  = (ccnt == CW'(BIT_CYCLES - 1));
    assign last_bit = (bcnt == BW'(WIDTH - 1));

    // The head of sreg is the bit on the line, so each advance moves the
    // next bit into the head position and back-fills with zero.
    assign shifted = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0}
                               : {1'b0, sreg[WIDTH-1:1]};

`ifdef PISO_PARITY_EN
    // Parity bit placed in the head position so sdata keeps tapping sreg.
    assign par_vec = MSB_FIRST ? {par_q, {(WIDTH-1){1'b0}}}
                               : {{(WIDTH-1){1'b0}}, par_q};
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            sreg     <= '0;
            bcnt     <= '0;
            ccnt     <= '0;
            sframe_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // load_ready is high in IDLE, so load_valid alone is the
                    // transfer condition here.
                    if (bus.load_valid) begin
                        state    <= ST_SHIFT;
                        sreg     <= bus.data_in;
                        bcnt     <= '0;
                        ccnt     <= '0;
                        sframe_q <= 1'b1;
`ifdef PISO_PARITY_EN
                        par_q    <= ^bus.data_in;
`endif
                    end
                end

                ST_SHIFT: begin
                    if (bit_end) begin
                        ccnt <= '0;
                        bcnt <= bcnt + BW'(1);
                        if (last_bit) begin
`ifdef PISO_PARITY_EN
                            state <= ST_PARITY;
                            sreg  <= par_vec;
`else
                            state    <= ST_IDLE;
                            sreg     <= '0;
                            sframe_q <= 1'b0;
                            done_q   <= 1'b1;
`endif
                        end else begin
                            sreg <= shifted;
                        end
                    end else begin
                        ccnt <= ccnt + CW'(1);
                    end
                end

`ifdef PISO_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        state    <= ST_IDLE;
                        ccnt     <= '0;
                        sreg     <= '0;
                        sframe_q <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        ccnt <= ccnt + CW'(1);
                    end
                end
`endif

                default: begin
                    // Unreachable encodings recover to a clean idle line.
                    state    <= ST_IDLE;
                    sreg     <= '0;
                    bcnt     <= '0;
                    ccnt     <= '0;
                    sframe_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.load_ready = (state == ST_IDLE);
    assign bus.sdata      = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
    assign bus.sframe     = sframe_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// ---------------------------------------------------------------------------
// tb_piso_serializer
//   Two serializers share clk/rst: d0 (MSB_FIRST=1, BIT_CYCLES=1) and
//   d1 (MSB_FIRST=0, BIT_CYCLES=3). Each has its own producer queue and a
//   reference model that, on every accepted word, lays out the whole
//   expected frame (bit list, each bit repeated BIT_CYCLES times, optional
//   parity, then one done cycle) into a queue consumed one entry per clock.
// ---------------------------------------------------------------------------
module tb_piso_serializer;

    localparam int W = 8;
`ifdef PISO_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    typedef struct packed {
        logic sd;
        logic sf;
        logic dn;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic force_ff = 1'b1;   // reset test: offer 0xFF continuously
    logic bb = 1'b0;         // offer the next word as soon as idle

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam bit MF = (g == 0);
        localparam int BC = (g == 0) ? 1 : 3;
        localparam int FL = (W + PAR) * BC;

        piso_serializer_if #(.WIDTH(W)) bus ();

        piso_serializer #(
            .WIDTH(W), .MSB_FIRST(MF), .BIT_CYCLES(BC)
        ) dut (
            .clk(clk), .rst(rst), .bus(bus)
        );

        exp_t       q[$];
        exp_t       cur = '0;
        logic [7:0] pend[$];
        bit         armed = 1'b0;
        int         flen = 0;

        initial begin
            bus.load_valid = 1'b0;
            bus.data_in    = '0;
        end

        // Reference model: one update per clock edge.
        always @(posedge clk) begin
            logic b;
            if (!rst) begin
                q.delete();
                cur = '0;
            end else if (!cur.sf && bus.load_valid) begin
                q.delete();
                for (int i = 0; i < W + PAR; i++) begin
                    if (i < W) b = MF ? bus.data_in[W-1-i] : bus.data_in[i];
                    else       b = ^bus.data_in;
                    for (int c = 0; c < BC; c++) q.push_back('{sd: b, sf: 1'b1, dn: 1'b0});
                end
                q.push_back('{sd: 1'b0, sf: 1'b0, dn: 1'b1});
                cur = q.pop_front();
                if (pend.size() != 0) void'(pend.pop_front());
            end else if (q.size() != 0) begin
                cur = q.pop_front();
            end else begin
                cur = '0;
            end
            armed = 1'b1;
        end

        // Check outputs mid-cycle, then drive the next inputs.
        always @(negedge clk) begin
            if (armed) begin
                chk($sformatf("d%0d sdata", g), 32'(bus.sdata), 32'(cur.sd));
                chk($sformatf("d%0d sframe", g), 32'(bus.sframe), 32'(cur.sf));
                chk($sformatf("d%0d done", g), 32'(bus.done), 32'(cur.dn));
                chk($sformatf("d%0d load_ready", g), 32'(bus.load_ready), 32'(!cur.sf));
                if (bus.done) chk($sformatf("d%0d frame_len", g), 32'(flen), 32'(FL));
                if (bus.sframe) flen++;
                else            flen = 0;
            end
            if (force_ff) begin
                bus.load_valid = 1'b1;
                bus.data_in    = 8'hFF;
            end else if (cur.sf) begin
                // Busy: random offers must be ignored.
                bus.load_valid = 1'($urandom_range(0, 1));
                bus.data_in    = 8'($urandom);
            end else begin
                bus.load_valid = (pend.size() != 0) && (bb || ($urandom_range(0, 1) == 1));
                bus.data_in    = (pend.size() != 0) ? pend[0] : 8'($urandom);
            end
        end
    end

    function automatic bit all_idle();
        return (g_dut[0].pend.size() == 0) && (g_dut[1].pend.size() == 0) &&
               (g_dut[0].q.size() == 0) && (g_dut[1].q.size() == 0) &&
               (g_dut[0].cur == exp_t'(0)) && (g_dut[1].cur == exp_t'(0));
    endfunction

    task automatic wait_idle(input int budget);
        int n = 0;
        while (n < budget && !all_idle()) begin
            @(posedge clk); #1;
            n++;
        end
        if (!all_idle()) chk("idle_timeout", 32'd0, 32'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic push_both(input logic [7:0] w);
        g_dut[0].pend.push_back(w);
        g_dut[1].pend.push_back(w);
    endtask

    initial begin
        int n;
        // Reset held with 0xFF offered: no frame may start.
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        force_ff = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Directed words, offered as soon as idle.
        bb = 1'b1;
        push_both(8'hA5);
        wait_idle(200);
        push_both(8'h81);
        wait_idle(200);

        // Back-to-back: second word accepted on the done cycle.
        push_both(8'h0F);
        push_both(8'hF0);
        wait_idle(200);

        // Parity-sensitive words (even and odd popcount).
        push_both(8'hA5);
        push_both(8'h07);
        wait_idle(200);

        // Reset during bit 4 of 0xA5 on d0, then a clean 0x3C.
        push_both(8'hA5);
        n = 0;
        while (n < 50 && !g_dut[0].cur.sf) begin
            @(posedge clk); #1;
            n++;
        end
        if (!g_dut[0].cur.sf) chk("start_timeout", 32'd0, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        g_dut[0].pend.delete();
        g_dut[1].pend.delete();
        push_both(8'h3C);
        wait_idle(200);

        // Random words with random offer gaps and busy-time noise.
        bb = 1'b0;
        for (int i = 0; i < 30; i++) begin
            g_dut[0].pend.push_back(8'($urandom));
            g_dut[1].pend.push_back(8'($urandom));
        end
        wait_idle(5000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
